// File: rtl/inport.sv
// Link-layer input port: recovers flits from an upstream toggle pair, buffers them in a
// FIFO of DEPTH entries, and returns one credit toggle per flit consumed downstream.
module inport #(
   parameter int DEPTH = 4
) (
   input  logic        clka,
   input  logic        rsta,
   input  logic [1:0]  diff_pair_din,
   input  logic [47:0] channel_din,
   output logic        valid_dout,
   output logic [47:0] flit_dout,
   input  logic        ack_din,
   output logic [1:0]  credit_dout,
   output logic        overflow_dout,
   output logic        pair_error_dout
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("inport: DEPTH must be a power of two and at least 2");
   end

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         pair_q, pair_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [1:0]         credit_q, credit_d;
   logic               overflow_q, overflow_d;
   logic               pair_error_q, pair_error_d;
   logic [47:0]        mem_q [DEPTH];

   logic pair_ok;
   logic arrival;
   logic pair_bad;
   logic pop;
   logic full;
   logic push;
   logic drop;

   assign pair_ok = diff_pair_din[1] != diff_pair_din[0];

   // Pair tracker: an arrival is one inversion of the p/n pair relative to the last valid value.
   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d  = state_q;
      pair_d   = pair_q;
      arrival  = 1'b0;
      pair_bad = 1'b0;
      case (state_q)
         RUN: begin
            if (!pair_ok) begin
               state_d  = HALT;
               pair_bad = 1'b1;
            end else begin
               arrival = diff_pair_din[1] != pair_q[1];
               pair_d  = diff_pair_din;
            end
         end
         HALT: begin
            // Resync on the first valid pair without emitting a flit.
            if (pair_ok) begin
               state_d = RUN;
               pair_d  = diff_pair_din;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // A full buffer still accepts an arrival when the head leaves on the same edge.
   assign pop  = valid_dout & ack_din;
   assign full = count_q == FULL_CNT;
   assign push = arrival & (~full | pop);
   assign drop = arrival & full & ~pop;

   always_comb begin
      wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d     = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      credit_d     = pop  ? ~credit_q : credit_q;
      overflow_d   = overflow_q | drop;
      pair_error_d = pair_error_q | pair_bad;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clka) begin
      if (rsta) begin
         state_q      <= RUN;
         pair_q       <= 2'b01;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         credit_q     <= 2'b01;
         overflow_q   <= 1'b0;
         pair_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pair_q       <= pair_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         credit_q     <= credit_d;
         overflow_q   <= overflow_d;
         pair_error_q <= pair_error_d;
      end
   end

   // NOTE: the flit storage has no reset; count and pointers alone decide which entries are live.
   always_ff @(posedge clka) begin
      if (!rsta && push) begin
         mem_q[wr_ptr_q] <= channel_din;
      end
   end

   assign valid_dout      = count_q != '0;
   assign flit_dout       = mem_q[rd_ptr_q];
   assign credit_dout     = credit_q;
   assign overflow_dout   = overflow_q;
   assign pair_error_dout = pair_error_q;

endmodule

// File: tb/tb_inport.sv
// Self-checking bench for inport: directed scenarios plus a randomized run, all checked
// against a queue-based reference model of the port's behaviour.
module tb_inport;

   localparam int DEPTH = 4;

   logic        clka = 1'b0;
   logic        rsta;
   logic [1:0]  diff_pair_din;
   logic [47:0] channel_din;
   logic        ack_din;
   logic        valid_dout;
   logic [47:0] flit_dout;
   logic [1:0]  credit_dout;
   logic        overflow_dout;
   logic        pair_error_dout;

   always #5 clka = ~clka;

   inport #(.DEPTH(DEPTH)) dut (
      .clka            (clka),
      .rsta            (rsta),
      .diff_pair_din   (diff_pair_din),
      .channel_din     (channel_din),
      .valid_dout      (valid_dout),
      .flit_dout       (flit_dout),
      .ack_din         (ack_din),
      .credit_dout     (credit_dout),
      .overflow_dout   (overflow_dout),
      .pair_error_dout (pair_error_dout)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: the buffer is a plain queue, the link a "last valid pair" plus a halted flag.
   logic [47:0] m_q [$];
   bit          m_halt;
   logic [1:0]  m_pair;
   logic [1:0]  m_credit;
   bit          m_ovf;
   bit          m_perr;

   logic [1:0]  cp;

   function automatic logic [47:0] rand48();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[47:0];
   endfunction

   task automatic model_step();
      logic [1:0] pr;
      bit arrival;
      bit pop;
      pr = diff_pair_din;
      if (rsta) begin
         m_q.delete();
         m_halt   = 0;
         m_pair   = 2'b01;
         m_credit = 2'b01;
         m_ovf    = 0;
         m_perr   = 0;
         return;
      end
      arrival = 0;
      pop     = (m_q.size() != 0) && (ack_din === 1'b1);
      if (pr[1] == pr[0]) begin
         m_perr = 1;
         m_halt = 1;
      end else begin
         arrival = !m_halt && (pr[1] != m_pair[1]);
         m_halt  = 0;
         m_pair  = pr;
      end
      if (pop) begin
         void'(m_q.pop_front());
         m_credit = ~m_credit;
      end
      if (arrival) begin
         if (m_q.size() < DEPTH) m_q.push_back(channel_din);
         else m_ovf = 1;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clka);
      #1;
   endtask

   task automatic drive(input logic r, input logic [1:0] p, input logic [47:0] d, input logic a);
      rsta          = r;
      diff_pair_din = p;
      channel_din   = d;
      ack_din       = a;
   endtask

   task automatic do_reset();
      cp = 2'b01;
      drive(1'b1, cp, rand48(), 1'b0);
      tick();
      tick();
      drive(1'b0, cp, rand48(), 1'b0);
   endtask

   task automatic arrive(input logic [47:0] d, input logic a);
      cp = ~cp;
      drive(1'b0, cp, d, a);
      tick();
   endtask

   task automatic test_reset();
      drive(1'b1, 2'b10, rand48(), 1'b1);
      tick();
      tick();
      n_checks++; if (valid_dout !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_dout); end
      n_checks++; if (credit_dout !== 2'b01) begin n_fail++; $display("FAIL reset_credit: got %b want 01", credit_dout); end
      n_checks++; if (overflow_dout !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow_dout); end
      n_checks++; if (pair_error_dout !== 1'b0) begin n_fail++; $display("FAIL reset_pair_error: got %b want 0", pair_error_dout); end
      cp = 2'b01;
      drive(1'b0, cp, rand48(), 1'b0);
      tick();
      n_checks++; if (valid_dout !== 1'b0) begin n_fail++; $display("FAIL reset_idle_valid: got %b want 0", valid_dout); end
   endtask

   task automatic test_single();
      do_reset();
      arrive(48'hA5A5_0000_0001, 1'b0);
      n_checks++; if (valid_dout !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", valid_dout); end
      n_checks++; if (flit_dout !== 48'hA5A5_0000_0001) begin n_fail++; $display("FAIL single_flit: got %h want a5a500000001", flit_dout); end
      drive(1'b0, cp, rand48(), 1'b1);
      tick();
      n_checks++; if (valid_dout !== 1'b0) begin n_fail++; $display("FAIL single_pop_valid: got %b want 0", valid_dout); end
      n_checks++; if (credit_dout !== 2'b10) begin n_fail++; $display("FAIL single_credit: got %b want 10", credit_dout); end
      drive(1'b0, cp, rand48(), 1'b1);
      tick();
      n_checks++; if (credit_dout !== 2'b10) begin n_fail++; $display("FAIL single_ack_ignored: got %b want 10", credit_dout); end
   endtask

   task automatic test_overflow();
      logic [1:0] exp_credit;
      do_reset();
      for (int i = 1; i <= 6; i++) arrive(48'(i), 1'b0);
      n_checks++; if (overflow_dout !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow_dout); end
      n_checks++; if (valid_dout !== 1'b1) begin n_fail++; $display("FAIL ovf_valid: got %b want 1", valid_dout); end
      exp_credit = 2'b01;
      drive(1'b0, cp, rand48(), 1'b1);
      for (int i = 1; i <= 4; i++) begin
         n_checks++; if (flit_dout !== 48'(i)) begin n_fail++; $display("FAIL ovf_drain_order%0d: got %0d want %0d", i, flit_dout, i); end
         tick();
         exp_credit = ~exp_credit;
         n_checks++; if (credit_dout !== exp_credit) begin n_fail++; $display("FAIL ovf_credit%0d: got %b want %b", i, credit_dout, exp_credit); end
      end
      n_checks++; if (valid_dout !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got %b want 0", valid_dout); end
      n_checks++; if (overflow_dout !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow_dout); end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      for (int i = 1; i <= 4; i++) arrive(48'h100 + 48'(i), 1'b0);
      arrive(48'h105, 1'b1);
      n_checks++; if (overflow_dout !== 1'b0) begin n_fail++; $display("FAIL full_pp_overflow: got %b want 0", overflow_dout); end
      drive(1'b0, cp, rand48(), 1'b1);
      for (int i = 2; i <= 5; i++) begin
         n_checks++; if (valid_dout !== 1'b1 || flit_dout !== 48'h100 + 48'(i)) begin
            n_fail++; $display("FAIL full_pp_order%0d: got v=%b %h want v=1 %h", i, valid_dout, flit_dout, 48'h100 + 48'(i));
         end
         tick();
      end
      n_checks++; if (valid_dout !== 1'b0) begin n_fail++; $display("FAIL full_pp_drained: got %b want 0", valid_dout); end
   endtask

   task automatic test_pair_error();
      do_reset();
      drive(1'b0, 2'b11, rand48(), 1'b0);
      tick();
      n_checks++; if (pair_error_dout !== 1'b1) begin n_fail++; $display("FAIL perr_flag: got %b want 1", pair_error_dout); end
      n_checks++; if (valid_dout !== 1'b0) begin n_fail++; $display("FAIL perr_no_flit_11: got %b want 0", valid_dout); end
      drive(1'b0, 2'b10, rand48(), 1'b0);
      tick();
      n_checks++; if (valid_dout !== 1'b0) begin n_fail++; $display("FAIL perr_resync_no_flit: got %b want 0", valid_dout); end
      tick();
      n_checks++; if (valid_dout !== 1'b0) begin n_fail++; $display("FAIL perr_hold_no_flit: got %b want 0", valid_dout); end
      drive(1'b0, 2'b01, 48'hBEEF_0000_0033, 1'b0);
      tick();
      n_checks++; if (valid_dout !== 1'b1 || flit_dout !== 48'hBEEF_0000_0033) begin
         n_fail++; $display("FAIL perr_next_flit: got v=%b %h want v=1 beef00000033", valid_dout, flit_dout);
      end
      drive(1'b0, 2'b01, rand48(), 1'b1);
      tick();
      n_checks++; if (valid_dout !== 1'b0) begin n_fail++; $display("FAIL perr_exactly_one: got %b want 0", valid_dout); end
      n_checks++; if (pair_error_dout !== 1'b1) begin n_fail++; $display("FAIL perr_sticky: got %b want 1", pair_error_dout); end
      cp = 2'b01;
   endtask

   task automatic test_reset_inflight();
      do_reset();
      for (int i = 1; i <= 3; i++) arrive(rand48(), 1'b0);
      drive(1'b0, cp, rand48(), 1'b1);
      tick();
      cp = ~cp;
      drive(1'b1, cp, rand48(), 1'b0);
      tick();
      n_checks++; if (valid_dout !== 1'b0) begin n_fail++; $display("FAIL rst_inflight_valid: got %b want 0", valid_dout); end
      n_checks++; if (credit_dout !== 2'b01) begin n_fail++; $display("FAIL rst_inflight_credit: got %b want 01", credit_dout); end
      cp = 2'b01;
      drive(1'b0, cp, rand48(), 1'b1);
      tick();
      n_checks++; if (valid_dout !== 1'b0) begin n_fail++; $display("FAIL rst_inflight_empty: got %b want 0", valid_dout); end
   endtask

   task automatic test_steady();
      int bad;
      do_reset();
      arrive(48'h77, 1'b0);
      drive(1'b0, cp, rand48(), 1'b1);
      tick();
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, cp, rand48(), 1'b0);
         tick();
         if (valid_dout !== 1'b0) bad++;
      end
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL steady_no_arrival: %0d cycles with valid high, want 0", bad); end
   endtask

   task automatic test_random();
      int r;
      logic [1:0] p;
      do_reset();
      for (int i = 0; i < 800; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 7) p = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
         else if (r < 55) begin cp = ~cp; p = cp; end
         else p = cp;
         drive(($urandom_range(0, 199) == 0), p, rand48(), ($urandom_range(0, 1) != 0));
         tick();
         n_checks++; if (valid_dout !== (m_q.size() != 0)) begin
            n_fail++; $display("FAIL rand_valid@%0d: got %b want %b", i, valid_dout, (m_q.size() != 0));
         end
         if (m_q.size() != 0) begin
            n_checks++; if (flit_dout !== m_q[0]) begin n_fail++; $display("FAIL rand_flit@%0d: got %h want %h", i, flit_dout, m_q[0]); end
         end
         n_checks++; if (credit_dout !== m_credit) begin n_fail++; $display("FAIL rand_credit@%0d: got %b want %b", i, credit_dout, m_credit); end
         n_checks++; if (overflow_dout !== m_ovf) begin n_fail++; $display("FAIL rand_overflow@%0d: got %b want %b", i, overflow_dout, m_ovf); end
         n_checks++; if (pair_error_dout !== m_perr) begin n_fail++; $display("FAIL rand_pair_error@%0d: got %b want %b", i, pair_error_dout, m_perr); end
      end
   endtask

   initial begin
      cp = 2'b01;
      drive(1'b1, cp, '0, 1'b0);
      test_reset();
      test_single();
      test_overflow();
      test_full_push_pop();
      test_pair_error();
      test_reset_inflight();
      test_steady();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
